// File: rtl/prism_sit_sequencer.sv
// PRISM SIT sequencer: walks the latch SIT one state at a time. Each state
// gets one ENTER cycle (load counter, drive outputs) followed by EVAL cycles
// that test one condition and choose the next state. A debug port can halt,
// single-step and force the state index.
// WIDTH must be at least 40 so the reserved field slice is well formed.
module prism_sit_sequencer #(
  parameter  int WIDTH  = 80,
  parameter  int DEPTH  = 8,
  localparam int A_BITS = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              debug_step,
  input  logic              debug_state_wr,
  input  logic [5:0]        debug_state_wdata,
  input  logic [15:0]       in_sig,
  output logic [A_BITS-1:0] raddr1,
  input  logic [WIDTH-1:0]  rdata1,
  output logic [7:0]        out_q,
  output logic              done,
  output logic              err,
  output logic [31:0]       status
);

  typedef enum logic [1:0] {
    PH_ENTER = 2'd0,
    PH_EVAL  = 2'd1,
    PH_STOP  = 2'd2
  } phase_t;

  localparam logic [6:0]        DEPTH_W = 7'(DEPTH);
  localparam logic [A_BITS-1:0] LAST    = A_BITS'(DEPTH - 1);

  phase_t            phase, phase_n;
  logic [A_BITS-1:0] cur_state, state_n;
  logic [15:0]       cnt, cnt_n;
  logic [7:0]        out_n;
  logic              done_n, err_n;

  // SIT entry fields
  logic [2:0]  e_jump;
  logic [3:0]  e_cond_sel;
  logic        e_cond_inv;
  logic [7:0]  e_out_val;
  logic [15:0] e_count_load;
  logic        e_use_count, e_inc_on_false, e_halt_on_true;
  logic        unused_rsvd;

  assign e_jump         = rdata1[2:0];
  assign e_cond_sel     = rdata1[6:3];
  assign e_cond_inv     = rdata1[7];
  assign e_out_val      = rdata1[15:8];
  assign e_count_load   = rdata1[31:16];
  assign e_use_count    = rdata1[32];
  assign e_inc_on_false = rdata1[33];
  assign e_halt_on_true = rdata1[34];
  assign unused_rsvd    = ^rdata1[WIDTH-1:35];

  logic       adv, raw, cond;
  logic [5:0] jump6;
  logic       jump_ok, wdata_ok;

  assign adv      = en | debug_step;
  assign raw      = e_use_count ? (cnt == 16'd0) : in_sig[e_cond_sel];
  assign cond     = raw ^ e_cond_inv;
  assign jump6    = {3'b000, e_jump};
  assign jump_ok  = {4'b0000, e_jump} < DEPTH_W;
  assign wdata_ok = {1'b0, debug_state_wdata} < DEPTH_W;

  assign raddr1 = cur_state;
  assign status = {err, done, phase, 6'b0, cnt, 6'(cur_state)};

  // Next-state logic: debug force beats everything, STOP only exits via force
  always_comb begin
    phase_n = phase;
    state_n = cur_state;
    cnt_n   = cnt;
    out_n   = out_q;
    done_n  = done;
    err_n   = err;
    if (debug_state_wr) begin
      phase_n = PH_ENTER;
      done_n  = 1'b0;
      if (wdata_ok) begin
        state_n = debug_state_wdata[A_BITS-1:0];
      end else begin
        state_n = '0;
        err_n   = 1'b1;
      end
    end else if (adv) begin
      case (phase)
        PH_ENTER: begin
          cnt_n   = e_count_load;
          out_n   = e_out_val;
          phase_n = PH_EVAL;
        end
        PH_EVAL: begin
          // zero test above uses cnt before this decrement
          if (e_use_count && cnt != 16'd0) cnt_n = cnt - 16'd1;
          if (cond && e_halt_on_true) begin
            phase_n = PH_STOP;
            done_n  = 1'b1;
          end else if (cond) begin
            phase_n = PH_ENTER;
            if (jump_ok) begin
              state_n = jump6[A_BITS-1:0];
            end else begin
              state_n = '0;
              err_n   = 1'b1;
            end
          end else if (e_inc_on_false) begin
            phase_n = PH_ENTER;
            state_n = (cur_state == LAST) ? '0 : cur_state + A_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State register with async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= PH_ENTER;
      cur_state <= '0;
      cnt       <= '0;
      out_q     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      phase     <= phase_n;
      cur_state <= state_n;
      cnt       <= cnt_n;
      out_q     <= out_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: doc/prism_sit_sequencer.md
Name: prism_sit_sequencer

Overview:
- Execution engine directly downstream of the PRISM latch SIT.
- Holds the current state index and drives it as the SIT read address.
- Consumes the addressed SIT entry to evaluate one input condition, run a per-state loop counter, pick the next state and drive registered state outputs.
- Debug-bus controllable: halt, single-step, force state.

Parameters:
WIDTH, 80, SIT entry width; must be >= 40.
DEPTH, 8, number of SIT states.
A_BITS, derived from DEPTH (same rule as the SIT: 1..6 bits), state index width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable (level)
debug_step  in  1  single-cycle pulse; advances one phase while en=0
debug_state_wr  in  1  force-state strobe
debug_state_wdata  in  6  forced state index
in_sig  in  16  condition inputs, synchronous to clk; no synchronisers inside
raddr1  out  A_BITS  SIT read address; equals cur_state, combinational
rdata1  in  WIDTH  SIT entry for raddr1, combinational from the SIT
out_q  out  8  registered state outputs
done  out  1  sequencer stopped by a halt_on_true state
err  out  1  sticky: illegal state index requested
status  out  32  {err, done, phase[1:0], 6'b0, cnt[15:0], pad, cur_state} zero-extended; bit 31 = err

Behaviour:
- Entry fields:
  - [2:0] jump_state
  - [6:3] cond_sel
  - [7] cond_inv
  - [15:8] out_val
  - [31:16] count_load
  - [32] use_count
  - [33] inc_on_false
  - [34] halt_on_true
  - [WIDTH-1:35] reserved, ignored
- Phases: ENTER, EVAL, STOP.
- Reset (async): cur_state=0, phase=ENTER, cnt=0, out_q=0, done=0, err=0.
- adv = en | debug_step. With adv=0 all registers hold (phase, cur_state, cnt, out_q).
- ENTER (adv=1), one cycle:
  - cnt <= count_load.
  - out_q <= out_val.
  - phase <= EVAL.
- EVAL (adv=1):
  - raw = use_count ? (cnt==0) : in_sig[cond_sel].
  - cond = raw ^ cond_inv.
  - If use_count and cnt!=0: cnt <= cnt-1. The zero test uses the pre-decrement value.
  - cond=1 and halt_on_true=1: phase <= STOP, done <= 1, cur_state holds.
  - cond=1 otherwise: cur_state <= jump_state, phase <= ENTER. This includes a self-jump, which reloads the counter.
  - cond=0 and inc_on_false=1: cur_state <= (cur_state==DEPTH-1) ? 0 : cur_state+1, phase <= ENTER.
  - cond=0 otherwise: remain in EVAL, cur_state holds.
- Illegal jump: jump_state >= DEPTH → cur_state <= 0, err <= 1, phase <= ENTER.
- STOP: holds everything regardless of en or debug_step. Exits only via debug_state_wr or reset.
- debug_state_wr:
  - Highest priority; acts regardless of adv or phase.
  - cur_state <= wdata[A_BITS-1:0]; phase <= ENTER; done <= 0.
  - wdata >= DEPTH → cur_state <= 0, err <= 1.
  - cnt and out_q hold until the ENTER executes.
- err clears only on reset.
- Timing:
  - State-entry latency is one ENTER cycle.
  - out_q changes on the ENTER edge, one clock after cur_state changes.
  - A state with use_count=1, cond_inv=0, count_load=N spends 1 ENTER + (N+1) EVAL cycles when en=1 continuously.
- debug_step while en=1 has no extra effect.
- A step pulse advances exactly one phase (ENTER or one EVAL).
- Reset mid-operation returns immediately to state 0 / ENTER and drops done and err.

Test Plan:
- Reset, SIT entry0 {out_val=8'hA5, use_count=1, count_load=3, jump_state=1}, entry1 {out_val=8'h3C}, en=1 → out_q=0xA5 after 1 clk; cur_state becomes 1 exactly 5 clks after en; out_q=0x3C on the next clk.
- Entry0 {cond_sel=5, cond_inv=0, jump_state=2, inc_on_false=0}, en=1, in_sig[5]=0 for 10 clks then 1 → stays in state 0 in EVAL; moves to state 2 the clk after in_sig[5] rises. Repeat with cond_inv=1 → moves on the first EVAL.
- DEPTH=8, state 7 {inc_on_false=1, cond false} → cur_state wraps to 0, err stays 0. Entry jump_state=7 with DEPTH=6 → cur_state=0, err=1 (sticky).
- en=0, pulse debug_step 3 times on entry {use_count=1, count_load=5} → ENTER, then two EVALs; status shows cnt=3 and phase=EVAL; no change between pulses.
- Entry {halt_on_true=1, cond true} → done=1, phase=STOP; toggling en and debug_step gives no change; debug_state_wr wdata=4 → done=0, cur_state=4, ENTER on the next adv.
- Assert rst_n low mid-EVAL in state 3 with cnt=9 → cur_state, cnt, out_q, done and err all 0 asynchronously; phase=ENTER.
